// File: rtl/req_encoder_4to2.sv
// req_encoder_4to2: latches request pulses into a pending set and
// grants one index at a time on a valid/ready handshake.
// Ports: clk, rst_n (async active-low), req_in[N_REQ],
//   out_valid/out_ready/out_idx[IDX_W] handshake, pending[N_REQ], drop.
// Build option: define REQ_ENC_ROUND_ROBIN_EN for round-robin selection;
//   when undefined, the lowest set index wins (fixed priority).
module req_encoder_4to2 #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [N_REQ-1:0] pending,
   output logic             drop
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic             drop_q, drop_d;
`ifdef REQ_ENC_ROUND_ROBIN_EN
   logic [IDX_W-1:0] last_q, last_d;
`endif

   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] sel_oh;
   logic [N_REQ-1:0] idx_oh;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_found;
   logic             load;

   assign cand   = pending_q | req_in;
   assign sel_oh = N_REQ'(1) << sel_idx;
   assign idx_oh = N_REQ'(1) << out_idx_q;
   assign load   = (state_q == IDLE) || out_ready;

   // Selection of the next index out of the candidate set.
`ifdef REQ_ENC_ROUND_ROBIN_EN
   always_comb begin
      int j;
      j         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      // Search begins just after the last grant and wraps around.
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(last_q) + k) % N_REQ;
         if (!sel_found && cand[j]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(j);
         end
      end
   end
`else
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      // Walk downward so the lowest set bit is the final winner.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (cand[k]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(k);
         end
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      pending_d   = pending_q;
      drop_d      = 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      if (load) begin
         if (sel_found) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_idx_d   = sel_idx;
            pending_d   = cand & ~sel_oh;
            // A bit served this edge is one grant, not a collision.
            drop_d      = |(req_in & pending_q & ~sel_oh);
`ifdef REQ_ENC_ROUND_ROBIN_EN
            last_d      = sel_idx;
`endif
         end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            pending_d   = '0;
         end
      end else begin
         // Stalled: a re-request of the shown index merges into
         // the grant already on the output.
         pending_d = pending_q | (req_in & ~idx_oh);
         drop_d    = |(req_in & pending_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         pending_q   <= '0;
         drop_q      <= 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
         last_q      <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         pending_q   <= pending_d;
         drop_q      <= drop_d;
`ifdef REQ_ENC_ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign pending   = pending_q;
   assign drop      = drop_q;

endmodule
